// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: bubble/halt encodings, data RAM sizing,
// halt FSM states and the EX/MEM register layout.
package mips_pkg;

    localparam logic [31:0] NOP           = 32'h0000_0000;
    localparam logic [31:0] HALT_SENTINEL = 32'hffff_ffff;
    localparam int          DEPTH_DEF     = 512;
    localparam int          AW_DEF        = 9;
    localparam int          DRAIN_DEF     = 2;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } halt_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] alu_out;
        logic [31:0] write_data;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic [4:0]  write_reg;
    } exmem_t;

endpackage

// File: rtl/mem_stage_if.sv
// Memory-stage bus: EX-side inputs, M/W pipeline outputs, status and debug port.
interface mem_stage_if #(parameter int AW = 9);

    logic        stallM, flushM;
    logic [31:0] instrE, alu_outE, write_dataE;
    logic        reg_writeE, mem_to_regE, mem_writeE;
    logic [4:0]  write_regE;

    logic [31:0] instrM, alu_outM;
    logic        reg_writeM;
    logic [4:0]  write_regM;

    logic [31:0] instrW, resultW;
    logic        reg_writeW;
    logic [4:0]  write_regW;

    logic          halted, misaligned_err;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_data;

    modport master (
        output stallM, flushM, instrE, alu_outE, write_dataE,
               reg_writeE, mem_to_regE, mem_writeE, write_regE, dbg_addr,
        input  instrM, alu_outM, reg_writeM, write_regM,
               instrW, reg_writeW, write_regW, resultW,
               halted, misaligned_err, dbg_data
    );

    modport slave (
        input  stallM, flushM, instrE, alu_outE, write_dataE,
               reg_writeE, mem_to_regE, mem_writeE, write_regE, dbg_addr,
        output instrM, alu_outM, reg_writeM, write_regM,
               instrW, reg_writeW, write_regW, resultW,
               halted, misaligned_err, dbg_data
    );

endinterface

// File: rtl/mem_stage_data_ram.sv
// Word-addressed data RAM: one synchronous write port, asynchronous load and
// debug read ports. Contents survive reset; zero only at time zero.
module data_ram #(
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata,
    input  logic [AW-1:0] dbg_addr,
    output logic [31:0]   dbg_data
);

    logic [31:0] mem [DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata    = mem[raddr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: EX/MEM register, data RAM access, MEM/WB register and the
// halt FSM that drains writeback after the sentinel and then freezes the stage.
module mem_stage
    import mips_pkg::*;
#(
    parameter int          DEPTH      = DEPTH_DEF,
    parameter int          AW         = AW_DEF,
    parameter logic [31:0] HALT_INSTR = HALT_SENTINEL,
    parameter int          DRAIN      = DRAIN_DEF
) (
    input logic         clk,
    input logic         reset,
    mem_stage_if.slave  s
);

    localparam int CW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    exmem_t        m_q, e_in;
    halt_state_e   st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          halted, squash, ram_we, mis_q;
    logic [AW-1:0] widx;
    logic [31:0]   ram_rdata;
    logic          unused_hi;

    assign halted = (st_q == ST_HALT);
    // Nothing from the sentinel onward may update architectural state.
    assign squash = (s.instrE == HALT_INSTR) || (m_q.instr == HALT_INSTR) || (st_q == ST_DRAIN);

    always_comb begin
        e_in = '{instr: s.instrE, alu_out: s.alu_outE, write_data: s.write_dataE,
                 reg_write: s.reg_writeE, mem_to_reg: s.mem_to_regE,
                 mem_write: s.mem_writeE, write_reg: s.write_regE};
        if (squash) begin
            e_in.reg_write  = 1'b0;
            e_in.mem_to_reg = 1'b0;
            e_in.mem_write  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)              m_q <= '0;
        else if (!halted) begin
            if (s.flushM)       m_q <= '0;
            else if (!s.stallM) m_q <= e_in;
        end
    end

    assign widx      = m_q.alu_out[AW+1:2];
    assign unused_hi = ^m_q.alu_out[31:AW+2];
    assign ram_we    = m_q.mem_write && !halted && !reset;

    data_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk      (clk),
        .we       (ram_we),
        .waddr    (widx),
        .wdata    (m_q.write_data),
        .raddr    (widx),
        .rdata    (ram_rdata),
        .dbg_addr (s.dbg_addr),
        .dbg_data (s.dbg_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s.instrW     <= NOP;
            s.reg_writeW <= 1'b0;
            s.write_regW <= '0;
            s.resultW    <= '0;
        end else if (!halted) begin
            s.instrW     <= m_q.instr;
            s.reg_writeW <= m_q.reg_write && (m_q.write_reg != 5'd0);
            s.write_regW <= m_q.write_reg;
            s.resultW    <= m_q.mem_to_reg ? ram_rdata : m_q.alu_out;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) mis_q <= 1'b0;
        else if (!halted && (m_q.mem_write || m_q.mem_to_reg) && (m_q.alu_out[1:0] != 2'b00))
            mis_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q  <= ST_RUN;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // The counter is loaded with DRAIN-1; HALT is entered on the edge it reaches 0.
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        case (st_q)
            ST_RUN: if (m_q.instr == HALT_INSTR) begin
                if (DRAIN <= 1) st_d = ST_HALT;
                else begin
                    st_d  = ST_DRAIN;
                    cnt_d = CW'(DRAIN - 1);
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) st_d = ST_HALT;
            end
            default: ;
        endcase
    end

    assign s.instrM         = m_q.instr;
    assign s.alu_outM       = m_q.alu_out;
    assign s.reg_writeM     = m_q.reg_write;
    assign s.write_regM     = m_q.write_reg;
    assign s.halted         = halted;
    assign s.misaligned_err = mis_q;

endmodule
